add_result_fifo: RTL
====================

# add_result_fifo

Buffered result stage directly downstream of the 16-bit ripple adder. It captures each `{cout, rslt}` pair the adder produces under a valid/ready handshake and queues it in a small FIFO. It presents results in order to the next consumer and keeps a saturating count of carry-out events. It decouples the purely combinational adder from a consumer that may stall.

## Interface
- `DEPTH`, 4, number of FIFO entries; power of two, ≥ 2.
- `CW`, `$clog2(DEPTH)+1`, width of `count`; derived, not overridden.

Ports:
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  adder result on `in_rslt`/`in_cout` is valid this cycle.
- `in_ready`  output  1  FIFO can accept a result this cycle.
- `in_rslt`  input  16  adder sum (adder `rslt`).
- `in_cout`  input  1  adder carry flag (adder `cout`).
- `out_valid`  output  1  head entry available.
- `out_ready`  input  1  consumer takes head entry this cycle.
- `out_data`  output  16  head entry sum.
- `out_cout`  output  1  head entry carry flag.
- `count`  output  CW  current occupancy, 0..DEPTH.
- `cout_cnt`  output  8  number of accepted results with carry = 1; saturates at 255.

## Operation
**Storage.** `DEPTH` × 17-bit array `{cout, data}`, plus `wr_ptr` and `rd_ptr` (each `log2(DEPTH)` bits, wrap modulo `DEPTH`) and a `count` register.

**Push and pop.**
- Push: `in_valid && in_ready`. Writes `mem[wr_ptr]`, then `wr_ptr++`.
- Pop: `out_valid && out_ready`. Increments `rd_ptr`.
- Count update:
  - push only: `count+1`.
  - pop only: `count-1`.
  - both: unchanged.
  - neither: unchanged.

**Status outputs.**
- `in_ready = (count != DEPTH)`, a combinational function of registered state only. It never depends on `out_ready`.
- `out_valid = (count != 0)`.
- `out_data`/`out_cout` are `mem[rd_ptr]` when `out_valid` is high, otherwise forced to 0.

**Carry counter.**
- `cout_cnt` increments on every push with `in_cout = 1` while it is below 255.
- It holds at 255 once reached.
- It is unaffected by pops.

**Boundary conditions.**
- Full (`count = DEPTH`): `in_ready = 0`. `in_valid` is ignored, including in a cycle where a pop happens; there is no same-cycle pass-through.
- Empty: `out_valid = 0` and `out_data = 0`. A push in this cycle appears at the output only on the next cycle; there is no bypass.
- Simultaneous push and pop at partial occupancy: both pointers advance and `count` is held.
- Pointer wrap: after `DEPTH` pushes, `wr_ptr` returns to 0. Ordering is preserved across the wrap.
- `in_rslt`/`in_cout` are sampled only on a push edge. Values while `in_valid = 0` have no effect.
- Consumer misbehaviour: a pop request with `out_ready = 1` while empty does nothing.

## Timing
- Reset (asynchronous assert, any time, including mid-stream) forces:
  - `wr_ptr = rd_ptr = 0`, `count = 0`, `cout_cnt = 0`.
  - `in_ready = 1`, `out_valid = 0`, `out_data = 0`, `out_cout = 0`.
  - Array contents are not reset and are never observable after reset.
- Latency from push to visible at the head of an empty FIFO: 1 cycle.
- Throughput: one push and one pop per cycle sustained when 0 < `count` < `DEPTH`.
- `in_ready` and `out_valid` change only after a clock edge or on reset.
- In-flight data is discarded on reset; the first push after deassertion lands in entry 0.

## Configuration
- `ADD_RESULT_FIFO_SAT_EN`:
  - **Defined:** a pushed entry with `in_cout = 1` stores data `16'hFFFF` (saturating unsigned add). The stored `cout` is still 1 and `cout_cnt` still increments.
  - **Undefined:** data is stored unmodified (wrap-around sum).
- No other behaviour differs between the two builds.

## Test plan
- Reset mid-stream: push 3 entries, assert `rst` asynchronously between edges → `count = 0`, `out_valid = 0`, `cout_cnt = 0` immediately. The next push of `16'h1234` appears as `out_data = 16'h1234`.
- Ordering across wrap: `out_ready = 0`, push `16'h0001`..`16'h0004` → `in_ready = 0` and `count = 4`. Then pop 2, push `16'h0005`, `16'h0006`, pop all → output sequence 3, 4, 5, 6.
- Full with pop: at full, `in_valid = 1` with `16'hAAAA` and `out_ready = 1` → head pops, `16'hAAAA` is not written, and `count = 3`.
- Carry handling: push `in_rslt = 16'h0000`, `in_cout = 1` (from `16'h8000 + 16'h8000`) → `out_cout = 1` and `cout_cnt = 1`. `out_data = 16'h0000` without the macro, `16'hFFFF` with `ADD_RESULT_FIFO_SAT_EN`.
- Streaming: `in_valid` and `out_ready` both held high for 100 cycles with incrementing data → `count` stays at 1 after the first cycle, no entry is lost or duplicated, and output lags input by 1 cycle.
- Counter saturation: 300 pushes with `in_cout = 1`, popping concurrently → `cout_cnt` reaches 255 and holds.

Source files
------------

// File: rtl/add_result_fifo.sv
// Result FIFO behind the 16-bit ripple adder: queues {cout, rslt} pairs and counts carry events.
// Optional build macro ADD_RESULT_FIFO_SAT_EN stores 16'hFFFF for carry results (saturating add).
module add_result_fifo #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_rslt,
  input  logic          in_cout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_data,
  output logic          out_cout,
  output logic [CW-1:0] count,
  output logic [7:0]    cout_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // Ready/valid derive only from registered occupancy, so full never passes through and
  // empty never bypasses.

  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [7:0]    cout_cnt_q;
  logic          push;
  logic          pop;
  logic [15:0]   wr_data;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef ADD_RESULT_FIFO_SAT_EN
  assign wr_data = in_cout ? 16'hFFFF : in_rslt;
`else
  assign wr_data = in_rslt;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_cout, wr_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      cout_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push && in_cout && (cout_cnt_q != 8'hFF)) begin
        cout_cnt_q <= cout_cnt_q + 8'd1;
      end
    end
  end

  // Stale array contents are masked so nothing leaks out while empty or after reset.
  always_comb begin
    out_data = '0;
    out_cout = 1'b0;
    if (out_valid) begin
      out_data = mem[rd_ptr][15:0];
      out_cout = mem[rd_ptr][16];
    end
  end

  assign count    = count_q;
  assign cout_cnt = cout_cnt_q;

endmodule
